// File: rtl/seq_shift_unit_pkg.sv
// Shared encodings and defaults for the iterative shifter.
package seq_shift_unit_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SHW   = 5;

   typedef enum logic [1:0] {
      OP_SLL  = 2'b00,
      OP_SRL  = 2'b01,
      OP_SRA  = 2'b10,
      OP_PASS = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/seq_shift_unit_shift_step.sv
// Single-bit shift for one iteration of the sequential shifter.
module shift_step
   import seq_shift_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] in_i,
   output logic [WIDTH-1:0] out_o
);

   // One position per call; pass-through leaves the value untouched.
   always_comb begin
      out_o = in_i;
      case (op_i)
         OP_SLL:  out_o = {in_i[WIDTH-2:0], 1'b0};
         OP_SRL:  out_o = {1'b0, in_i[WIDTH-1:1]};
         OP_SRA:  out_o = {in_i[WIDTH-1], in_i[WIDTH-1:1]};
         default: out_o = in_i;
      endcase
   end

endmodule

// File: rtl/seq_shift_unit.sv
// Iterative shifter: one bit per clock, result feeds the destination register.
//
// state | meaning
// IDLE  | waiting for start, result holds last value
// SHIFT | shifting one position per cycle, busy = 1
// DONE  | result valid for exactly one cycle, done = 1
module seq_shift_unit
   import seq_shift_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SHW   = DEF_SHW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [SHW-1:0]   shamt,
   input  logic             kill,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

   state_e           state_q;
   op_e              op_q;
   logic [SHW-1:0]   cnt_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result_d;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .op_i  (op_q),
      .in_i  (result_q),
      .out_o (result_d)
   );

   // Sequencer: reset beats kill beats start; a new start may be taken in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= OP_SLL;
         cnt_q    <= '0;
         result_q <= '0;
      end else if (kill) begin
         // Partial result is left in place; it is simply never flagged done.
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  result_q <= a;
                  op_q     <= op_e'(op);
                  cnt_q    <= shamt;
                  state_q  <= (shamt != '0 && op != OP_PASS) ? SHIFT : DONE;
               end else begin
                  state_q <= IDLE;
               end
            end
            SHIFT: begin
               result_q <= result_d;
               cnt_q    <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy   = (state_q == SHIFT);
   assign done   = (state_q == DONE);
   assign result = result_q;

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Multi-cycle iterative shifter for the miniRISC shift instructions (logical left, logical right, arithmetic right).
- Sits directly upstream of the destination Register stage.
- result drives the Register D input; done drives its RegWrEnbl.
- Shifts one bit position per clock, so a shift by n costs n+1 cycles. This replaces a large combinational barrel shifter in the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHW, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the unit is not busy.
- op  input  2  00 = SLL, 01 = SRL, 10 = SRA, 11 = pass-through (result = a).
- a  input  WIDTH  operand to shift; captured on accepted start.
- shamt  input  SHW  shift amount 0..WIDTH-1; captured on accepted start.
- kill  input  1  synchronous abort of the operation in flight (pipeline flush).
- busy  output  1  high while shifting; start is ignored while busy = 1.
- done  output  1  one-cycle pulse; result is valid and must be written this cycle.
- result  output  WIDTH  shifted value; holds until the next accepted start.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - All state updates on the rising edge of clk.
  - Reset is synchronous and active-high.
- Reset (rst = 1 at an edge):
  - state = IDLE, result = 0, done = 0, busy = 0, cnt = 0, op_q = 0.
  - rst has priority over kill and start.
  - Reset mid-operation discards the operation; no done is produced.
- States: IDLE, SHIFT, DONE.
  - busy = (state == SHIFT).
  - done = (state == DONE).
  - Both outputs are decoded from registered state; no combinational path from inputs.
- Accept rule:
  - start is accepted at an edge when state is IDLE or DONE and kill = 0.
  - On accept: result <= a, op_q <= op, cnt <= shamt.
  - Next state is SHIFT if shamt != 0 and op != 11, else DONE.
  - start while in SHIFT is ignored; the operation in flight is unaffected and nothing is queued.
- SHIFT state, at each edge:
  - SLL: result <= {result[WIDTH-2:0], 0}.
  - SRL: result <= {0, result[WIDTH-1:1]}.
  - SRA: result <= {result[WIDTH-1], result[WIDTH-1:1]}.
  - cnt <= cnt - 1.
  - When cnt == 1 at the edge, go to DONE. Otherwise stay in SHIFT.
- DONE state:
  - Lasts exactly one cycle.
  - Next state is SHIFT or DONE if a new start is accepted (back-to-back), else IDLE.
- Latency:
  - done is high in the cycle after the (n+1)th edge counted from the accepting edge inclusive, where n = shamt.
  - Minimum latency is 1 cycle (shamt = 0, or op = 11).
  - Maximum latency is WIDTH cycles (shamt = WIDTH-1).
- kill (with rst = 0):
  - Forces state to IDLE and clears done and cnt.
  - result holds its current (partial) value and must not be consumed.
  - kill in the same edge as start: kill wins; the start is dropped.
  - kill in DONE: that cycle's done pulse is already visible and is not retracted; next state is IDLE.
- Outputs and holding:
  - result is stable from the done cycle until the next accepted start.
  - Outside SHIFT, result never changes except on start or rst.
- Arithmetic:
  - No overflow flag; bits shifted out are discarded.
  - shamt is unsigned.
  - SRA replicates bit WIDTH-1 of the captured operand.

Decomposition:
- Shared package holds:
  - op encodings: OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_PASS = 2'b11.
  - state encodings: IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10.
  - defaults WIDTH = 32, SHW = 5.
- One combinational sub-module is natural: shift_step (WIDTH, op, in -> out, a single-bit shift).
  - Instantiated once inside seq_shift_unit.
  - Unit-testable on its own.
- The FSM, counter and result register stay in the top module.

Test Plan:
- SLL, a = 0x00000001, shamt = 4 -> busy high for 4 cycles; done for exactly 1 cycle at latency 5; result = 0x00000010.
- SRA, a = 0x80000000, shamt = 31 -> done at latency 32, result = 0xFFFFFFFF. Same with SRL -> result = 0x00000001.
- shamt = 0 (any op), or op = 11 with shamt = 7, a = 0xDEADBEEF -> no busy; done at latency 1; result = 0xDEADBEEF.
- SRL, a = 0xF0000000, shamt = 8, with start re-pulsed (a = 0x1, shamt = 1) during SHIFT -> second start ignored; result = 0x00F00000 at latency 9.
- Back-to-back: start asserted again in the DONE cycle (SLL, a = 0x3, shamt = 2) -> first done seen; second done 3 cycles later with result = 0xC; no IDLE cycle between.
- kill at the 3rd SHIFT cycle of an SLL by 10, then separately rst at the 3rd SHIFT cycle -> no done pulse, busy = 0 next cycle. After rst, result = 0. A new start then completes normally.
